if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 65 ++++++
 tb/tb_if_id_stage.sv | 136 +++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: program counter, IF/ID pipeline register with stall/squash control, and stall/redirect counters.
module if_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pc_write,
   input  logic             if_id_write,
   input  logic             flush,
   input  logic [31:0]      branch_target,
   input  logic             jump,
   input  logic [31:0]      jump_target,
   input  logic [31:0]      imem_instr,
   output logic [31:0]      imem_addr,
   output logic [31:0]      if_id_pc4,
   output logic [31:0]      if_id_instr,
   output logic             if_id_valid,
   output logic [4:0]       if_id_rs,
   output logic [4:0]       if_id_rt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   logic [31:0]      r_pc, r_pc4, r_instr;
   logic             r_valid;
   logic [CNT_W-1:0] r_stall, r_flush;
   logic [31:0]      w_pc4, w_target;
   logic             w_redirect;
   assign w_pc4      = r_pc + 32'd4;
   assign w_redirect = flush | jump;
   // flush outranks jump when both are raised together
   assign w_target   = flush ? branch_target : jump_target;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= {RESET_PC[31:2], 2'b00};
         r_pc4   <= '0;
         r_instr <= '0;
         r_valid <= 1'b0;
         r_stall <= '0;
         r_flush <= '0;
      end else begin
         if (w_redirect) r_pc <= {w_target[31:2], 2'b00};
         else if (pc_write) r_pc <= {w_pc4[31:2], 2'b00};
         if (w_redirect) begin
            r_pc4   <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
         end else if (if_id_write) begin
            r_pc4   <= w_pc4;
            r_instr <= imem_instr;
            r_valid <= 1'b1;
         end
         if (!w_redirect && !pc_write && r_stall != {CNT_W{1'b1}}) r_stall <= r_stall + 1'b1;
         if (w_redirect && r_flush != {CNT_W{1'b1}}) r_flush <= r_flush + 1'b1;
      end
   end
   assign imem_addr   = r_pc;
   assign if_id_pc4   = r_pc4;
   assign if_id_instr = r_instr;
   assign if_id_valid = r_valid;
   assign if_id_rs    = r_instr[25:21];
   assign if_id_rt    = r_instr[20:16];
   assign stall_cnt   = r_stall;
   assign flush_cnt   = r_flush;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed scoreboard bench for if_id_stage (default and wrap-around RESET_PC instances).
module tb_if_id_stage;
   logic        clk = 1'b0;
   logic        reset, pc_write, if_id_write, flush, jump;
   logic [31:0] branch_target, jump_target;
   logic [31:0] imem_instr, imem_addr, if_id_pc4, if_id_instr;
   logic        if_id_valid;
   logic [4:0]  if_id_rs, if_id_rt;
   logic [15:0] stall_cnt, flush_cnt;
   logic [31:0] imem_instr1, imem_addr1, if_id_pc41, if_id_instr1;
   logic        if_id_valid1;
   logic [4:0]  if_id_rs1, if_id_rt1;
   logic [15:0] stall_cnt1, flush_cnt1;
   int          passes = 0, total = 0;

   typedef struct {
      string       tag;
      logic [31:0] pc, pc4, instr;
      logic        valid;
      logic [15:0] stall, fl;
   } exp_t;
   exp_t sb[$];

   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'h2001_0005 + a;
   endfunction

   assign imem_instr  = mem(imem_addr);
   assign imem_instr1 = mem(imem_addr1);

   always #5 clk = ~clk;

   if_id_stage dut (
      .clk(clk), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
      .flush(flush), .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
      .imem_instr(imem_instr), .imem_addr(imem_addr), .if_id_pc4(if_id_pc4),
      .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .if_id_rs(if_id_rs),
      .if_id_rt(if_id_rt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk(clk), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
      .flush(flush), .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
      .imem_instr(imem_instr1), .imem_addr(imem_addr1), .if_id_pc4(if_id_pc41),
      .if_id_instr(if_id_instr1), .if_id_valid(if_id_valid1), .if_id_rs(if_id_rs1),
      .if_id_rt(if_id_rt1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic drive(input logic rs, input logic pw, input logic iw, input logic fl,
                        input logic [31:0] bt, input logic jp, input logic [31:0] jt);
      reset = rs; pc_write = pw; if_id_write = iw; flush = fl;
      branch_target = bt; jump = jp; jump_target = jt;
   endtask

   task automatic expect_state(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                               input logic [31:0] instr, input logic valid,
                               input logic [15:0] st, input logic [15:0] fc);
      exp_t e;
      e.tag = tag; e.pc = pc; e.pc4 = pc4; e.instr = instr; e.valid = valid; e.stall = st; e.fl = fc;
      sb.push_back(e);
   endtask

   task automatic edge_check();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      chk({e.tag, "_pc"},    imem_addr,   e.pc);
      chk({e.tag, "_pc4"},   if_id_pc4,   e.pc4);
      chk({e.tag, "_instr"}, if_id_instr, e.instr);
      chk({e.tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
      chk({e.tag, "_rs"},    {27'd0, if_id_rs}, {27'd0, e.instr[25:21]});
      chk({e.tag, "_rt"},    {27'd0, if_id_rt}, {27'd0, e.instr[20:16]});
      chk({e.tag, "_stall"}, {16'd0, stall_cnt}, {16'd0, e.stall});
      chk({e.tag, "_flush"}, {16'd0, flush_cnt}, {16'd0, e.fl});
   endtask

   initial begin
      drive(1, 1, 1, 0, 0, 0, 0);
      expect_state("reset", 0, 0, 0, 0, 0, 0); edge_check();
      drive(0, 1, 1, 0, 0, 0, 0);
      expect_state("run1", 4, 4, mem(0), 1, 0, 0); edge_check();
      expect_state("run2", 8, 8, mem(4), 1, 0, 0); edge_check();
      drive(0, 0, 0, 0, 0, 0, 0);
      expect_state("stall1", 8, 8, mem(4), 1, 1, 0); edge_check();
      expect_state("stall2", 8, 8, mem(4), 1, 2, 0); edge_check();
      drive(0, 1, 1, 0, 0, 0, 0);
      expect_state("resume", 12, 12, mem(8), 1, 2, 0); edge_check();
      expect_state("run16", 16, 16, mem(12), 1, 2, 0); edge_check();
      drive(0, 1, 1, 1, 32'h40, 0, 0);
      expect_state("flush", 32'h40, 0, 0, 0, 2, 1); edge_check();
      drive(0, 1, 1, 0, 0, 0, 0);
      expect_state("after_flush", 32'h44, 32'h44, mem(32'h40), 1, 2, 1); edge_check();
      drive(0, 0, 0, 1, 32'h80, 1, 32'hC0);
      expect_state("flush_jump", 32'h80, 0, 0, 0, 2, 2); edge_check();
      drive(0, 1, 1, 0, 0, 1, 32'h13);
      expect_state("jump_align", 32'h10, 0, 0, 0, 2, 3); edge_check();
      drive(0, 0, 1, 0, 0, 0, 0);
      expect_state("dup_fetch", 32'h10, 32'h14, mem(32'h10), 1, 3, 3); edge_check();
      drive(0, 1, 0, 0, 0, 0, 0);
      expect_state("lost_fetch", 32'h14, 32'h14, mem(32'h10), 1, 3, 3); edge_check();
      drive(0, 1, 1, 0, 0, 0, 0);
      expect_state("run18", 32'h18, 32'h18, mem(32'h14), 1, 3, 3); edge_check();
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (65540) @(posedge clk);
      expect_state("stall_sat", 32'h18, 32'h18, mem(32'h14), 1, 16'hFFFF, 3); edge_check();
      expect_state("stall_sat2", 32'h18, 32'h18, mem(32'h14), 1, 16'hFFFF, 3); edge_check();
      drive(1, 0, 0, 1, 32'h80, 1, 32'hC0);
      expect_state("reset_mid", 0, 0, 0, 0, 0, 0); edge_check();
      chk("dut1_reset_pc", imem_addr1, 32'hFFFF_FFFC);
      chk("dut1_reset_valid", {31'd0, if_id_valid1}, 32'd0);
      drive(0, 1, 1, 0, 0, 0, 0);
      expect_state("post_reset", 4, 4, mem(0), 1, 0, 0); edge_check();
      chk("dut1_wrap_pc", imem_addr1, 32'h0);
      chk("dut1_wrap_pc4", if_id_pc41, 32'h0);
      chk("dut1_wrap_instr", if_id_instr1, mem(32'hFFFF_FFFC));
      chk("dut1_wrap_valid", {31'd0, if_id_valid1}, 32'd1);
      drive(0, 1, 1, 0, 0, 1, 32'h13);
      expect_state("post_jump", 32'h10, 0, 0, 0, 0, 1); edge_check();
      chk("dut1_jump_pc", imem_addr1, 32'h10);
      chk("dut1_jump_flush", {16'd0, flush_cnt1}, 32'd1);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
